// File: rtl/ex_wb_pkg.sv
// Shared types for the execute/write-back arbiter: muldiv FSM states and the
// CDB payload record carried through the ALU result FIFO and the output mux.
package ex_wb_pkg;

  localparam int XLEN      = 32;
  // Payload tag field is sized for the widest supported ROB tag.
  localparam int TAG_W_MAX = 16;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_PEND,
    MD_HOLD,
    MD_DROP
  } md_state_t;

  typedef struct packed {
    logic [TAG_W_MAX-1:0] tag;
    logic [XLEN-1:0]      data;
    logic                 z;
    logic                 is_md;
  } cdb_payload_t;

endpackage

// File: rtl/ex_wb_arbiter_if.sv
// Common data bus handshake: the arbiter drives valid and payload, the
// consumer answers with ready.
interface ex_wb_arbiter_if #(
  parameter int TAG_W = 5
);
  import ex_wb_pkg::*;

  logic             cdb_valid;
  logic             cdb_ready;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;
  logic             cdb_z;
  logic             cdb_is_md;

  modport master (
    output cdb_valid, cdb_tag, cdb_data, cdb_z, cdb_is_md,
    input  cdb_ready
  );

  modport slave (
    input  cdb_valid, cdb_tag, cdb_data, cdb_z, cdb_is_md,
    output cdb_ready
  );

endinterface

// File: rtl/ex_wb_fifo.sv
// Synchronous ALU result FIFO with registered storage, first-word-fall-through
// head and a registered occupancy count. clr empties it at the next edge.
module ex_wb_fifo
  import ex_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  cdb_payload_t      wr_data,
  input  logic              rd_en,
  output cdb_payload_t      rd_data,
  output logic [CNT_W-1:0]  count
);

  cdb_payload_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Storage carries no reset: the head is only looked at while count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/ex_wb_arbiter.sv
// Merges single-cycle ALU results (queued in a FIFO) and one outstanding
// muldiv result onto the CDB; a held muldiv result outranks the FIFO head.
module ex_wb_arbiter
  import ex_wb_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_z,
  input  logic              md_issue,
  input  logic [TAG_W-1:0]  md_issue_tag,
  input  logic              md_done,
  input  logic [XLEN-1:0]   md_result,
  input  logic              flush,
  ex_wb_arbiter_if.master   cdb,
  output logic              alu_stall,
  output logic              md_issue_ok,
  output logic              err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  md_state_t        state_reg, state_next;
  logic [TAG_W-1:0] md_tag_reg, md_tag_next;
  logic [XLEN-1:0]  md_data_reg, md_data_next;
  logic             err_reg, err_next;

  logic             fifo_full, fifo_empty, hold_sel, cdb_valid, xfer;
  logic             fifo_wr, fifo_rd;
  logic [CNT_W-1:0] fifo_count;
  cdb_payload_t     fifo_in, fifo_head, sel;
  logic             unused_sel_bits;

  assign fifo_full  = (fifo_count == CNT_W'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign hold_sel   = (state_reg == MD_HOLD);
  assign cdb_valid  = (hold_sel || !fifo_empty) && !flush;
  assign xfer       = cdb_valid && cdb.cdb_ready;
  assign fifo_wr    = alu_valid && !fifo_full && !flush;
  assign fifo_rd    = xfer && !hold_sel;

  always_comb begin
    fifo_in       = '0;
    fifo_in.tag   = TAG_W_MAX'(alu_tag);
    fifo_in.data  = alu_result;
    fifo_in.z     = alu_z;
    fifo_in.is_md = 1'b0;
  end

  ex_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .wr_en   (fifo_wr),
    .wr_data (fifo_in),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  always_comb begin
    state_next   = state_reg;
    md_tag_next  = md_tag_reg;
    md_data_next = md_data_reg;
    err_next     = err_reg || (alu_valid && fifo_full) ||
                   (md_issue && state_reg != MD_IDLE);
    case (state_reg)
      MD_IDLE: begin
        if (md_issue) begin
          md_tag_next = md_issue_tag;
          state_next  = flush ? MD_DROP : MD_PEND;
        end
      end
      MD_PEND: begin
        // A completion coinciding with flush is already squashed, so go straight home.
        if (flush && md_done) begin
          state_next = MD_IDLE;
        end else if (flush) begin
          state_next = MD_DROP;
        end else if (md_done) begin
          state_next   = MD_HOLD;
          md_data_next = md_result;
        end
      end
      MD_HOLD: begin
        if (flush || xfer) state_next = MD_IDLE;
      end
      MD_DROP: begin
        if (md_done) state_next = MD_IDLE;
      end
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= MD_IDLE;
      md_tag_reg  <= '0;
      md_data_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      md_tag_reg  <= md_tag_next;
      md_data_reg <= md_data_next;
      err_reg     <= err_next;
    end
  end

  // Payload is forced to zero whenever nothing is being offered.
  always_comb begin
    sel = '0;
    if (cdb_valid) begin
      if (hold_sel) begin
        sel.tag   = TAG_W_MAX'(md_tag_reg);
        sel.data  = md_data_reg;
        sel.z     = 1'b0;
        sel.is_md = 1'b1;
      end else begin
        sel = fifo_head;
      end
    end
  end

  assign unused_sel_bits = ^sel;

  assign cdb.cdb_valid = cdb_valid;
  assign cdb.cdb_tag   = sel.tag[TAG_W-1:0];
  assign cdb.cdb_data  = sel.data;
  assign cdb.cdb_z     = sel.z;
  assign cdb.cdb_is_md = sel.is_md;
  assign alu_stall     = fifo_full;
  assign md_issue_ok   = (state_reg == MD_IDLE);
  assign err           = err_reg;

endmodule

// File: tb/tb_ex_wb_arbiter.sv
// Self-checking bench: ALU-path vector table, hand-written muldiv/flush/reset
// sequences, then random traffic against a queue-based reference model.
module tb_ex_wb_arbiter;
  import ex_wb_pkg::*;

  localparam int TAG_W = 5;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             alu_valid, alu_z, md_issue, md_done, flush;
  logic [TAG_W-1:0] alu_tag, md_issue_tag;
  logic [31:0]      alu_result, md_result;
  logic             alu_stall, md_issue_ok, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_wb_arbiter_if #(.TAG_W(TAG_W)) cdb_if ();

  ex_wb_arbiter #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_tag      (alu_tag),
    .alu_result   (alu_result),
    .alu_z        (alu_z),
    .md_issue     (md_issue),
    .md_issue_tag (md_issue_tag),
    .md_done      (md_done),
    .md_result    (md_result),
    .flush        (flush),
    .cdb          (cdb_if),
    .alu_stall    (alu_stall),
    .md_issue_ok  (md_issue_ok),
    .err          (err)
  );

  // One line per CDB transfer.
  always @(negedge clk) begin
    if (cdb_if.cdb_valid === 1'b1 && cdb_if.cdb_ready === 1'b1)
      $display("xfer t=%0t tag=%0d data=%h z=%b md=%b", $time, cdb_if.cdb_tag,
               cdb_if.cdb_data, cdb_if.cdb_z, cdb_if.cdb_is_md);
  end

  task automatic check(input string name, input logic ev, input logic [TAG_W-1:0] etag,
                       input logic [31:0] edata, input logic ez, input logic emd,
                       input logic estall, input logic eok, input logic eerr);
    logic [42:0] got, exp;
    got = {cdb_if.cdb_valid, cdb_if.cdb_tag, cdb_if.cdb_data, cdb_if.cdb_z,
           cdb_if.cdb_is_md, alu_stall, md_issue_ok, err};
    exp = {ev, etag, edata, ez, emd, estall, eok, eerr};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got v=%b tag=%0d data=%h z=%b md=%b stall=%b ok=%b err=%b; expected v=%b tag=%0d data=%h z=%b md=%b stall=%b ok=%b err=%b",
               name, $time, cdb_if.cdb_valid, cdb_if.cdb_tag, cdb_if.cdb_data, cdb_if.cdb_z,
               cdb_if.cdb_is_md, alu_stall, md_issue_ok, err,
               ev, etag, edata, ez, emd, estall, eok, eerr);
    end
  endtask

  // Start a cycle: inputs change 1 ns after the rising edge, all idle by default.
  task automatic begin_cyc(input logic rdy);
    @(posedge clk);
    #1;
    rst = 1'b0; alu_valid = 1'b0; alu_tag = '0; alu_result = '0; alu_z = 1'b0;
    md_issue = 1'b0; md_issue_tag = '0; md_done = 1'b0; md_result = '0; flush = 1'b0;
    cdb_if.cdb_ready = rdy;
  endtask

  task automatic do_reset();
    begin_cyc(1'b0); rst = 1'b1;
    begin_cyc(1'b0); rst = 1'b1;
  endtask

  // ---------------- ALU path vector table ----------------
  typedef struct {
    logic             av;
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic             z;
    logic             rdy;
    logic             ev;
    logic [TAG_W-1:0] etag;
    logic [31:0]      edata;
    logic             ez;
    logic             estall;
    logic             eerr;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic av, input int tag, input logic [31:0] res,
                              input logic z, input logic rdy, input logic ev, input int etag,
                              input logic [31:0] edata, input logic ez, input logic estall,
                              input logic eerr);
    vec_t v;
    v.av = av; v.tag = TAG_W'(tag); v.res = res; v.z = z; v.rdy = rdy;
    v.ev = ev; v.etag = TAG_W'(etag); v.edata = edata; v.ez = ez;
    v.estall = estall; v.eerr = eerr;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             z;
  } ent_t;

  ent_t             m_q [$];
  bit               m_busy, m_have, m_squash, m_err;
  logic [TAG_W-1:0] m_tag;
  logic [31:0]      m_data;
  logic             x_valid, x_z, x_md;
  logic [TAG_W-1:0] x_tag;
  logic [31:0]      x_data;

  task automatic model_reset();
    m_q.delete();
    m_busy = 0; m_have = 0; m_squash = 0; m_err = 0; m_tag = '0; m_data = '0;
  endtask

  task automatic model_expect();
    x_valid = (m_have || m_q.size() != 0) && !flush;
    x_tag = '0; x_data = '0; x_z = 1'b0; x_md = 1'b0;
    if (x_valid && m_have) begin
      x_tag = m_tag; x_data = m_data; x_md = 1'b1;
    end else if (x_valid) begin
      x_tag = m_q[0].tag; x_data = m_q[0].data; x_z = m_q[0].z;
    end
  endtask

  task automatic model_step();
    bit   idle, xfer;
    int   sz;
    ent_t e;
    idle = !m_busy && !m_have;
    sz   = m_q.size();
    xfer = x_valid && cdb_if.cdb_ready;
    if (rst) begin
      model_reset();
      return;
    end
    if ((alu_valid && sz == DEPTH) || (md_issue && !idle)) m_err = 1;
    if (flush) begin
      m_q.delete();
    end else begin
      if (xfer && !m_have) e = m_q.pop_front();
      if (alu_valid && sz < DEPTH) begin
        e.tag = alu_tag; e.data = alu_result; e.z = alu_z;
        m_q.push_back(e);
      end
    end
    if (idle) begin
      if (md_issue) begin
        m_busy = 1; m_squash = flush; m_tag = md_issue_tag;
      end
    end else if (m_busy) begin
      if (md_done) begin
        m_busy = 0;
        if (!m_squash && !flush) begin
          m_have = 1; m_data = md_result;
        end
      end else if (flush) begin
        m_squash = 1;
      end
    end else if (flush || xfer) begin
      m_have = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // av tag res z rdy | ev etag edata ez stall err
    tbl[0]  = mk(0, 0,  32'h0,   0, 1, 0, 0,  32'h0,   0, 0, 0);
    tbl[1]  = mk(1, 3,  32'h5,   0, 1, 0, 0,  32'h0,   0, 0, 0);
    tbl[2]  = mk(0, 0,  32'h0,   0, 1, 1, 3,  32'h5,   0, 0, 0);
    tbl[3]  = mk(0, 0,  32'h0,   0, 0, 0, 0,  32'h0,   0, 0, 0);
    tbl[4]  = mk(1, 1,  32'h101, 1, 0, 0, 0,  32'h0,   0, 0, 0);
    tbl[5]  = mk(1, 2,  32'h102, 0, 0, 1, 1,  32'h101, 1, 0, 0);
    tbl[6]  = mk(1, 3,  32'h103, 1, 0, 1, 1,  32'h101, 1, 0, 0);
    tbl[7]  = mk(1, 4,  32'h104, 0, 0, 1, 1,  32'h101, 1, 0, 0);
    tbl[8]  = mk(1, 5,  32'h105, 1, 0, 1, 1,  32'h101, 1, 1, 0);
    tbl[9]  = mk(0, 0,  32'h0,   0, 0, 1, 1,  32'h101, 1, 1, 1);
    tbl[10] = mk(0, 0,  32'h0,   0, 1, 1, 1,  32'h101, 1, 1, 1);
    tbl[11] = mk(0, 0,  32'h0,   0, 1, 1, 2,  32'h102, 0, 0, 1);
    tbl[12] = mk(0, 0,  32'h0,   0, 1, 1, 3,  32'h103, 1, 0, 1);
    tbl[13] = mk(0, 0,  32'h0,   0, 1, 1, 4,  32'h104, 0, 0, 1);
    tbl[14] = mk(0, 0,  32'h0,   0, 1, 0, 0,  32'h0,   0, 0, 1);
    tbl[15] = mk(1, 6,  32'h106, 0, 0, 0, 0,  32'h0,   0, 0, 1);
    tbl[16] = mk(1, 7,  32'h107, 1, 0, 1, 6,  32'h106, 0, 0, 1);
    tbl[17] = mk(1, 8,  32'h108, 0, 0, 1, 6,  32'h106, 0, 0, 1);
    tbl[18] = mk(1, 9,  32'h109, 1, 0, 1, 6,  32'h106, 0, 0, 1);
    tbl[19] = mk(1, 10, 32'h10A, 0, 1, 1, 6,  32'h106, 0, 1, 1);
    tbl[20] = mk(0, 0,  32'h0,   0, 1, 1, 7,  32'h107, 1, 0, 1);
    tbl[21] = mk(1, 11, 32'h10B, 1, 1, 1, 8,  32'h108, 0, 0, 1);
    tbl[22] = mk(0, 0,  32'h0,   0, 1, 1, 9,  32'h109, 1, 0, 1);
    tbl[23] = mk(0, 0,  32'h0,   0, 1, 1, 11, 32'h10B, 1, 0, 1);
    tbl[24] = mk(0, 0,  32'h0,   0, 1, 0, 0,  32'h0,   0, 0, 1);

    cdb_if.cdb_ready = 1'b0;
    do_reset();

    for (int i = 0; i < 25; i++) begin
      begin_cyc(tbl[i].rdy);
      alu_valid = tbl[i].av; alu_tag = tbl[i].tag; alu_result = tbl[i].res; alu_z = tbl[i].z;
      @(negedge clk);
      check($sformatf("alu_vec%0d", i), tbl[i].ev, tbl[i].etag, tbl[i].edata, tbl[i].ez,
            1'b0, tbl[i].estall, 1'b1, tbl[i].eerr);
    end

    // Held muldiv result overtakes an already-queued ALU result.
    do_reset();
    begin_cyc(0); md_issue = 1; md_issue_tag = 7;
    @(negedge clk); check("prio_issue", 0, 0, 0, 0, 0, 0, 1, 0);
    begin_cyc(0); alu_valid = 1; alu_tag = 2; alu_result = 32'h202;
    @(negedge clk); check("prio_pend", 0, 0, 0, 0, 0, 0, 0, 0);
    begin_cyc(0);
    @(negedge clk); check("prio_fifo_head", 1, 2, 32'h202, 0, 0, 0, 0, 0);
    begin_cyc(0); md_done = 1; md_result = 32'hFFFF_FFFE;
    @(negedge clk); check("prio_done", 1, 2, 32'h202, 0, 0, 0, 0, 0);
    begin_cyc(1);
    @(negedge clk); check("prio_md_first", 1, 7, 32'hFFFF_FFFE, 0, 1, 0, 0, 0);
    begin_cyc(1);
    @(negedge clk); check("prio_alu_second", 1, 2, 32'h202, 0, 0, 0, 1, 0);
    begin_cyc(1);
    @(negedge clk); check("prio_drained", 0, 0, 0, 0, 0, 0, 1, 0);

    // Flush while pending: the late completion is swallowed.
    begin_cyc(1); md_issue = 1; md_issue_tag = 9;
    @(negedge clk); check("drop_issue", 0, 0, 0, 0, 0, 0, 1, 0);
    begin_cyc(1); flush = 1;
    @(negedge clk); check("drop_flush", 0, 0, 0, 0, 0, 0, 0, 0);
    begin_cyc(1);
    @(negedge clk); check("drop_wait1", 0, 0, 0, 0, 0, 0, 0, 0);
    begin_cyc(1);
    @(negedge clk); check("drop_wait2", 0, 0, 0, 0, 0, 0, 0, 0);
    begin_cyc(1); md_done = 1; md_result = 32'h1234;
    @(negedge clk); check("drop_done", 0, 0, 0, 0, 0, 0, 0, 0);
    begin_cyc(1);
    @(negedge clk); check("drop_idle", 0, 0, 0, 0, 0, 0, 1, 0);
    begin_cyc(1); md_done = 1; md_result = 32'h4321;
    @(negedge clk); check("idle_done_ignored", 0, 0, 0, 0, 0, 0, 1, 0);
    begin_cyc(1);
    @(negedge clk); check("idle_done_no_cdb", 0, 0, 0, 0, 0, 0, 1, 0);

    // Flush and completion in the same pending cycle.
    begin_cyc(1); md_issue = 1; md_issue_tag = 12;
    @(negedge clk); check("fd_issue", 0, 0, 0, 0, 0, 0, 1, 0);
    begin_cyc(1); md_done = 1; md_result = 32'hCAFE; flush = 1;
    @(negedge clk); check("fd_same_cycle", 0, 0, 0, 0, 0, 0, 0, 0);
    begin_cyc(1);
    @(negedge clk); check("fd_idle", 0, 0, 0, 0, 0, 0, 1, 0);
    begin_cyc(1);
    @(negedge clk); check("fd_no_tag", 0, 0, 0, 0, 0, 0, 1, 0);

    // Flush empties the FIFO and blocks the same-cycle enqueue.
    begin_cyc(0); alu_valid = 1; alu_tag = 20; alu_result = 32'h20;
    @(negedge clk); check("fl_enq1", 0, 0, 0, 0, 0, 0, 1, 0);
    begin_cyc(0); alu_valid = 1; alu_tag = 21; alu_result = 32'h21;
    @(negedge clk); check("fl_enq2", 1, 20, 32'h20, 0, 0, 0, 1, 0);
    begin_cyc(1); alu_valid = 1; alu_tag = 22; alu_result = 32'h22; flush = 1;
    @(negedge clk); check("fl_flush_cycle", 0, 0, 0, 0, 0, 0, 1, 0);
    begin_cyc(1);
    @(negedge clk); check("fl_empty", 0, 0, 0, 0, 0, 0, 1, 0);

    // Reset while holding a result, plus md_issue outside IDLE raising err.
    begin_cyc(0); md_issue = 1; md_issue_tag = 13;
    @(negedge clk); check("rh_issue", 0, 0, 0, 0, 0, 0, 1, 0);
    begin_cyc(0); md_done = 1; md_result = 32'hABC;
    @(negedge clk); check("rh_done", 0, 0, 0, 0, 0, 0, 0, 0);
    begin_cyc(0); md_issue = 1; md_issue_tag = 14;
    @(negedge clk); check("rh_hold_bad_issue", 1, 13, 32'hABC, 0, 1, 0, 0, 0);
    begin_cyc(0);
    @(negedge clk); check("rh_hold_stable", 1, 13, 32'hABC, 0, 1, 0, 0, 1);
    begin_cyc(0); rst = 1;
    @(negedge clk); check("rh_rst_cycle", 1, 13, 32'hABC, 0, 1, 0, 0, 1);
    begin_cyc(0);
    @(negedge clk); check("rh_after_rst", 0, 0, 0, 0, 0, 0, 1, 0);
    begin_cyc(1); md_done = 1; md_result = 32'h55;
    @(negedge clk); check("rh_late_done", 0, 0, 0, 0, 0, 0, 1, 0);
    begin_cyc(1);
    @(negedge clk); check("rh_late_done_ign", 0, 0, 0, 0, 0, 0, 1, 0);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      begin_cyc(1'($urandom_range(99) < 45));
      rst          = ($urandom_range(249) == 0);
      alu_valid    = ($urandom_range(99) < 60);
      alu_tag      = TAG_W'($urandom);
      alu_result   = $urandom;
      alu_z        = 1'($urandom);
      md_issue     = ($urandom_range(99) < 15);
      md_issue_tag = TAG_W'($urandom);
      md_done      = ($urandom_range(99) < 25);
      md_result    = $urandom;
      flush        = ($urandom_range(99) < 4);
      @(negedge clk);
      model_expect();
      check($sformatf("rand%0d", n), x_valid, x_tag, x_data, x_z, x_md,
            1'(m_q.size() == DEPTH), 1'(!m_busy && !m_have), m_err);
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
